// File: rtl/simd_dot3_mac.sv
// simd_dot3_mac: 3-element unsigned dot-product MAC fed by the SIMD register file read ports.
// Optional saturating accumulation with a sticky ovf flag when SIMD_DOT3_SATURATE_EN is defined.
`timescale 1ns/1ps

module simd_dot3_mac #(
    parameter int NUM_BEATS = 3,
    parameter int ACC_W     = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       a0,
    input  logic [7:0]       a1,
    input  logic [7:0]       a2,
    input  logic [7:0]       b0,
    input  logic [7:0]       b1,
    input  logic [7:0]       b2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] result,
    output logic             busy,
    output logic             ovf
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [17:0]       prod_q;
    logic              p_valid_q;
    logic [ACC_W-1:0]  acc_q;
    logic [ACC_W-1:0]  result_q;
    logic [ACC_W-1:0]  acc_nxt;
    logic              accept;
    logic              clr;

    // Each 8x8 product fits 16 bits; the three-term sum peaks at 195075, inside 18 bits.
    function automatic logic [17:0] dot3(input logic [7:0] x0, input logic [7:0] x1,
                                         input logic [7:0] x2, input logic [7:0] y0,
                                         input logic [7:0] y1, input logic [7:0] y2);
        logic [15:0] m0, m1, m2;
        m0 = x0 * y0;
        m1 = x1 * y1;
        m2 = x2 * y2;
        return {2'b00, m0} + {2'b00, m1} + {2'b00, m2};
    endfunction

`ifdef SIMD_DOT3_SATURATE_EN
    logic              ovf_q;
    logic              ovf_hit;
    logic [ACC_W:0]    sat_res;

    // Returns {overflowed, clamped sum}.
    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] acc,
                                               input logic [17:0] p);
        logic [ACC_W:0] sum;
        sum = {1'b0, acc} + (ACC_W+1)'(p);
        if (sum[ACC_W]) begin
            return {1'b1, {ACC_W{1'b1}}};
        end
        return sum;
    endfunction

    assign sat_res = sat_add(acc_q, prod_q);
    assign acc_nxt = sat_res[ACC_W-1:0];
    assign ovf_hit = sat_res[ACC_W];
    assign ovf     = ovf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (clr) begin
            ovf_q <= 1'b0;
        end else if (p_valid_q && ovf_hit) begin
            ovf_q <= 1'b1;
        end
    end
`else
    function automatic logic [ACC_W-1:0] wrap_add(input logic [ACC_W-1:0] acc,
                                                  input logic [17:0] p);
        return acc + ACC_W'(p);
    endfunction

    assign acc_nxt = wrap_add(acc_q, prod_q);
    assign ovf     = 1'b0;
`endif

    assign in_ready  = (state_q == S_ACC);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign result    = result_q;
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ACC;
                    cnt_d   = 4'd0;
                    clr     = 1'b1;
                end
            end
            S_ACC: begin
                if (accept) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'(NUM_BEATS - 1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Stage 1 registers the dot product; stage 2 folds it into acc and mirrors it to result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            prod_q    <= '0;
            p_valid_q <= 1'b0;
            acc_q     <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            p_valid_q <= accept;
            if (accept) begin
                prod_q <= dot3(a0, a1, a2, b0, b1, b2);
            end
            if (clr) begin
                acc_q <= '0;
            end else if (p_valid_q) begin
                acc_q <= acc_nxt;
            end
            // result is left alone by start so it keeps the previous job's value in IDLE.
            if (p_valid_q) begin
                result_q <= acc_nxt;
            end
        end
    end

endmodule
